// File: rtl/cache_controller_msg_receiver.sv
// Receive-side front end of the cache controller: buffers NI responses and forwarded
// requests in separate FIFOs and presents one message at a time to stage 1.
package cache_controller_msg_pkg;
    typedef struct packed {
        logic [1:0]  packet_type;
        logic [31:0] address;
        logic [3:0]  source_tile;
        logic [31:0] data;
    } coherence_response_message_t;

    typedef struct packed {
        logic [1:0]  packet_type;
        logic [31:0] address;
        logic [3:0]  requestor_tile;
    } coherence_forwarded_message_t;
endpackage

module cache_controller_msg_receiver
    import cache_controller_msg_pkg::*;
#(
    parameter int FIFO_DEPTH            = 4,
    parameter int ALMOST_FULL_THRESHOLD = FIFO_DEPTH - 2,
    parameter int STARVE_LIMIT          = 3,
    parameter int TILE_ID               = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ni_response_valid,
    input  coherence_response_message_t  ni_response,
    input  logic                         ni_forwarded_request_valid,
    input  coherence_forwarded_message_t ni_forwarded_request,
    output logic                         cc_response_almost_full,
    output logic                         cc_forwarded_almost_full,
    output logic                         ccin_msg_valid,
    output logic                         ccin_msg_is_response,
    output coherence_response_message_t  ccin_response,
    output coherence_forwarded_message_t ccin_forwarded_request,
    input  logic                         cc1_msg_consumed,
    output logic                         ccin_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_THRESHOLD);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    coherence_response_message_t  resp_mem_q [FIFO_DEPTH];
    coherence_forwarded_message_t fwd_mem_q  [FIFO_DEPTH];
    logic [PTR_W-1:0] resp_rd_q, resp_wr_q, fwd_rd_q, fwd_wr_q;
    logic [CNT_W-1:0] resp_cnt_q, resp_cnt_d, fwd_cnt_q, fwd_cnt_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             valid_q, valid_d, is_resp_q, is_resp_d, overflow_q, overflow_d;
    logic             consume, resp_deq, fwd_deq, resp_full, fwd_full;
    logic             resp_enq, fwd_enq, resp_drop, fwd_drop;

    // A full FIFO still accepts when the presented head leaves it this same cycle.
    assign consume   = valid_q & cc1_msg_consumed;
    assign resp_deq  = consume & is_resp_q;
    assign fwd_deq   = consume & ~is_resp_q;
    assign resp_full = (resp_cnt_q == FULL_CNT);
    assign fwd_full  = (fwd_cnt_q == FULL_CNT);
    assign resp_enq  = ni_response_valid & (~resp_full | resp_deq);
    assign fwd_enq   = ni_forwarded_request_valid & (~fwd_full | fwd_deq);
    assign resp_drop = ni_response_valid & ~resp_enq;
    assign fwd_drop  = ni_forwarded_request_valid & ~fwd_enq;

    assign resp_cnt_d = resp_cnt_q + CNT_W'(resp_enq) - CNT_W'(resp_deq);
    assign fwd_cnt_d  = fwd_cnt_q + CNT_W'(fwd_enq) - CNT_W'(fwd_deq);
    assign overflow_d = overflow_q | resp_drop | fwd_drop;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        starve_d  = starve_q;
        valid_d   = valid_q;
        is_resp_d = is_resp_q;
        if (fwd_deq || fwd_cnt_q == '0) begin
            starve_d = '0;
        end else if (resp_deq && starve_q != STV_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        // Re-arbitrate only when nothing is locked in front of stage 1.
        if (!valid_q || consume) begin
            valid_d   = (resp_cnt_d != '0) || (fwd_cnt_d != '0);
            is_resp_d = (resp_cnt_d != '0) && ((fwd_cnt_d == '0) || (starve_d != STV_MAX));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the storage is reset too, so the payload outputs read 0 after reset, never X.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                resp_mem_q[i] <= '0;
                fwd_mem_q[i]  <= '0;
            end
            resp_rd_q  <= '0;
            resp_wr_q  <= '0;
            resp_cnt_q <= '0;
            fwd_rd_q   <= '0;
            fwd_wr_q   <= '0;
            fwd_cnt_q  <= '0;
            starve_q   <= '0;
            valid_q    <= 1'b0;
            is_resp_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (resp_enq) begin
                resp_mem_q[resp_wr_q] <= ni_response;
                resp_wr_q             <= resp_wr_q + 1'b1;
            end
            if (fwd_enq) begin
                fwd_mem_q[fwd_wr_q] <= ni_forwarded_request;
                fwd_wr_q            <= fwd_wr_q + 1'b1;
            end
            if (resp_deq) resp_rd_q <= resp_rd_q + 1'b1;
            if (fwd_deq)  fwd_rd_q  <= fwd_rd_q + 1'b1;
            resp_cnt_q <= resp_cnt_d;
            fwd_cnt_q  <= fwd_cnt_d;
            starve_q   <= starve_d;
            valid_q    <= valid_d;
            is_resp_q  <= is_resp_d;
            overflow_q <= overflow_d;
        end
    end

    assign ccin_msg_valid           = valid_q;
    assign ccin_msg_is_response     = is_resp_q;
    assign ccin_response            = resp_mem_q[resp_rd_q];
    assign ccin_forwarded_request   = fwd_mem_q[fwd_rd_q];
    assign cc_response_almost_full  = (resp_cnt_q >= AF_CNT);
    assign cc_forwarded_almost_full = (fwd_cnt_q >= AF_CNT);
    assign ccin_overflow            = overflow_q;
endmodule

// File: tb/tb_cache_controller_msg_receiver.sv
// Directed bench for cache_controller_msg_receiver: handshake latency, arbitration
// order, lock stability, almost_full/overflow, full-FIFO pass-through and async reset.
module tb_cache_controller_msg_receiver;
    import cache_controller_msg_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic ni_response_valid, ni_forwarded_request_valid, cc1_msg_consumed;
    coherence_response_message_t  ni_response, ccin_response;
    coherence_forwarded_message_t ni_forwarded_request, ccin_forwarded_request;
    logic cc_response_almost_full, cc_forwarded_almost_full;
    logic ccin_msg_valid, ccin_msg_is_response, ccin_overflow;

    int errors = 0;
    int checks = 0;

    cache_controller_msg_receiver dut (
        .clk                        (clk),
        .reset                      (reset),
        .ni_response_valid          (ni_response_valid),
        .ni_response                (ni_response),
        .ni_forwarded_request_valid (ni_forwarded_request_valid),
        .ni_forwarded_request       (ni_forwarded_request),
        .cc_response_almost_full    (cc_response_almost_full),
        .cc_forwarded_almost_full   (cc_forwarded_almost_full),
        .ccin_msg_valid             (ccin_msg_valid),
        .ccin_msg_is_response       (ccin_msg_is_response),
        .ccin_response              (ccin_response),
        .ccin_forwarded_request     (ccin_forwarded_request),
        .cc1_msg_consumed           (cc1_msg_consumed),
        .ccin_overflow              (ccin_overflow)
    );

    always #5 clk = ~clk;

    function automatic coherence_response_message_t mk_resp(input logic [31:0] addr);
        coherence_response_message_t m;
        m.packet_type = addr[5:4];
        m.address     = addr;
        m.source_tile = addr[3:0];
        m.data        = ~addr;
        return m;
    endfunction

    function automatic coherence_forwarded_message_t mk_fwd(input logic [31:0] addr);
        coherence_forwarded_message_t m;
        m.packet_type    = addr[7:6];
        m.address        = addr;
        m.requestor_tile = addr[3:0] ^ 4'hF;
        return m;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input coherence_response_message_t obs,
                         input coherence_response_message_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_f(input string tag, input coherence_forwarded_message_t obs,
                         input coherence_forwarded_message_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  grant_is_resp;
        logic [31:0] ra, fa;

        reset = 1'b1;
        ni_response_valid = 1'b0;
        ni_forwarded_request_valid = 1'b0;
        ni_response = '0;
        ni_forwarded_request = '0;
        cc1_msg_consumed = 1'b0;
        repeat (2) tick();

        chk1("rst_valid", ccin_msg_valid, 1'b0);
        chk1("rst_is_resp", ccin_msg_is_response, 1'b0);
        chk1("rst_af_resp", cc_response_almost_full, 1'b0);
        chk1("rst_af_fwd", cc_forwarded_almost_full, 1'b0);
        chk1("rst_overflow", ccin_overflow, 1'b0);
        chk_r("rst_resp_payload", ccin_response, '0);
        chk_f("rst_fwd_payload", ccin_forwarded_request, '0);
        reset = 1'b0;
        tick();

        // Single response: visible the cycle after enqueue, gone the cycle after consume.
        ni_response_valid = 1'b1;
        ni_response = mk_resp(32'h1000);
        #1;
        chk1("t1_no_fallthrough", ccin_msg_valid, 1'b0);
        tick();
        ni_response_valid = 1'b0;
        chk1("t1_valid", ccin_msg_valid, 1'b1);
        chk1("t1_is_resp", ccin_msg_is_response, 1'b1);
        chk_r("t1_payload", ccin_response, mk_resp(32'h1000));
        cc1_msg_consumed = 1'b1;
        tick();
        cc1_msg_consumed = 1'b0;
        chk1("t1_valid_after_consume", ccin_msg_valid, 1'b0);

        // Four of each class, then drain at full rate: R,R,R,F,R,F,F,F.
        for (int i = 0; i < 4; i++) begin
            ni_response_valid = 1'b1;
            ni_response = mk_resp(32'h2000 + 32'(i) * 32'h40);
            ni_forwarded_request_valid = 1'b1;
            ni_forwarded_request = mk_fwd(32'h3000 + 32'(i) * 32'h40);
            tick();
        end
        ni_response_valid = 1'b0;
        ni_forwarded_request_valid = 1'b0;
        chk1("t2_af_resp", cc_response_almost_full, 1'b1);
        chk1("t2_af_fwd", cc_forwarded_almost_full, 1'b1);
        grant_is_resp = 8'b1110_1000;
        ra = 32'h2000;
        fa = 32'h3000;
        cc1_msg_consumed = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk1($sformatf("t2_valid_%0d", k), ccin_msg_valid, 1'b1);
            chk1($sformatf("t2_grant_%0d", k), ccin_msg_is_response, grant_is_resp[7-k]);
            if (grant_is_resp[7-k]) begin
                chk_r($sformatf("t2_resp_%0d", k), ccin_response, mk_resp(ra));
                ra = ra + 32'h40;
            end else begin
                chk_f($sformatf("t2_fwd_%0d", k), ccin_forwarded_request, mk_fwd(fa));
                fa = fa + 32'h40;
            end
            tick();
        end
        cc1_msg_consumed = 1'b0;
        chk1("t2_drained", ccin_msg_valid, 1'b0);

        // Presented forwarded request stays locked while responses arrive.
        ni_forwarded_request_valid = 1'b1;
        ni_forwarded_request = mk_fwd(32'h4000);
        tick();
        ni_forwarded_request_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ni_response_valid = (i < 4);
            ni_response = mk_resp(32'h5000 + 32'(i));
            chk1($sformatf("t3_valid_%0d", i), ccin_msg_valid, 1'b1);
            chk1($sformatf("t3_is_resp_%0d", i), ccin_msg_is_response, 1'b0);
            chk_f($sformatf("t3_payload_%0d", i), ccin_forwarded_request, mk_fwd(32'h4000));
            tick();
        end
        ni_response_valid = 1'b0;
        cc1_msg_consumed = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("t3_r_is_resp_%0d", i), ccin_msg_is_response, 1'b1);
            chk_r($sformatf("t3_r_payload_%0d", i), ccin_response, mk_resp(32'h5000 + 32'(i)));
            tick();
        end
        cc1_msg_consumed = 1'b0;
        chk1("t3_drained", ccin_msg_valid, 1'b0);

        // Full FIFO with simultaneous enqueue and consume: no overflow, order kept across wrap.
        for (int i = 0; i < 4; i++) begin
            ni_response_valid = 1'b1;
            ni_response = mk_resp(32'h7000 + 32'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk_r($sformatf("t5_head_%0d", i), ccin_response, mk_resp(32'h7000 + 32'(i)));
            ni_response = mk_resp(32'h7004 + 32'(i));
            cc1_msg_consumed = 1'b1;
            tick();
        end
        ni_response_valid = 1'b0;
        chk1("t5_af_still", cc_response_almost_full, 1'b1);
        chk1("t5_no_overflow", ccin_overflow, 1'b0);
        for (int i = 3; i < 7; i++) begin
            chk1($sformatf("t5_valid_%0d", i), ccin_msg_valid, 1'b1);
            chk_r($sformatf("t5_head_%0d", i), ccin_response, mk_resp(32'h7000 + 32'(i)));
            tick();
        end
        cc1_msg_consumed = 1'b0;
        chk1("t5_drained", ccin_msg_valid, 1'b0);
        chk1("t5_overflow_final", ccin_overflow, 1'b0);

        // Almost-full after the second entry, fifth enqueue dropped with sticky overflow.
        for (int i = 0; i < 5; i++) begin
            ni_response_valid = 1'b1;
            ni_response = mk_resp(32'h6000 + 32'(i));
            tick();
            if (i == 0) chk1("t4_af_after1", cc_response_almost_full, 1'b0);
            if (i == 1) chk1("t4_af_after2", cc_response_almost_full, 1'b1);
            if (i == 3) chk1("t4_no_ovf_at4", ccin_overflow, 1'b0);
        end
        ni_response_valid = 1'b0;
        chk1("t4_overflow", ccin_overflow, 1'b1);
        cc1_msg_consumed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("t4_valid_%0d", i), ccin_msg_valid, 1'b1);
            chk_r($sformatf("t4_head_%0d", i), ccin_response, mk_resp(32'h6000 + 32'(i)));
            tick();
        end
        cc1_msg_consumed = 1'b0;
        chk1("t4_only_four", ccin_msg_valid, 1'b0);
        chk1("t4_af_cleared", cc_response_almost_full, 1'b0);
        chk1("t4_overflow_sticky", ccin_overflow, 1'b1);

        // Asynchronous reset mid-operation flushes everything at once.
        for (int i = 0; i < 3; i++) begin
            ni_response_valid = 1'b1;
            ni_response = mk_resp(32'h8000 + 32'(i));
            tick();
        end
        ni_response_valid = 1'b0;
        chk1("t6_pre_valid", ccin_msg_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("t6_valid", ccin_msg_valid, 1'b0);
        chk1("t6_is_resp", ccin_msg_is_response, 1'b0);
        chk1("t6_af_resp", cc_response_almost_full, 1'b0);
        chk1("t6_overflow", ccin_overflow, 1'b0);
        chk_r("t6_resp_payload", ccin_response, '0);
        chk_f("t6_fwd_payload", ccin_forwarded_request, '0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk1("t6_idle_after_release", ccin_msg_valid, 1'b0);
        ni_forwarded_request_valid = 1'b1;
        ni_forwarded_request = mk_fwd(32'h9000);
        tick();
        ni_forwarded_request_valid = 1'b0;
        chk1("t6_new_valid", ccin_msg_valid, 1'b1);
        chk1("t6_new_is_resp", ccin_msg_is_response, 1'b0);
        chk_f("t6_new_payload", ccin_forwarded_request, mk_fwd(32'h9000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
